alu_operand_issue: RTL and testbench
====================================

# alu_operand_issue

Operand issue stage directly upstream of the 32-bit bitwise logic units (OR, AND, XOR) in the RISC-V ALU. It accepts decoded register/immediate operands and funct3 through a valid/ready handshake, selects operand b, decodes funct3 to a logic-op select, and presents registered `a`, `b` and `op` to the logic units. A two-entry buffer (output register plus skid register) lets it sustain one operation per cycle under back-pressure without a combinational ready path.

## Interface
Parameters:
- `WIDTH`, 32, operand width in bits.
- `CNT_W`, 16, width of the issued-operation counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  upstream offers an operation.
- `in_ready`  out  1  stage can accept; registered.
- `in_rs1`  in  WIDTH  register operand 1.
- `in_rs2`  in  WIDTH  register operand 2.
- `in_imm`  in  WIDTH  sign-extended immediate.
- `in_use_imm`  in  1  1 selects `in_imm` for b, 0 selects `in_rs2`.
- `in_funct3`  in  3  RISC-V funct3.
- `out_valid`  out  1  `a`/`b`/`op`/`illegal` valid.
- `out_ready`  in  1  logic unit consumes the output.
- `a`  out  WIDTH  operand a (= rs1).
- `b`  out  WIDTH  operand b (rs2 or imm).
- `op`  out  2  00 none, 01 OR, 10 AND, 11 XOR.
- `illegal`  out  1  funct3 is not a logic op.
- `issue_count`  out  CNT_W  count of completed output handshakes.

## Operation
- Accept: `in_valid && in_ready`. Transfer: `out_valid && out_ready`.
- Decode at accept: funct3 110 → op 01, 111 → op 10, 100 → op 11. Any other funct3 → op 00 with `illegal`=1. The operation is still issued, not dropped.
- b = `in_use_imm` ? `in_imm` : `in_rs2`. Both are captured at accept.
- Storage: output register (OUT) and skid register (SKID), each with a valid bit. The state is EMPTY, ONE (OUT valid) or FULL (both valid).
- Accept when OUT is empty or being transferred: the entry loads OUT.
- Accept when OUT is valid and not transferring: the entry loads SKID.
- Transfer with SKID valid: SKID moves to OUT and SKID empties.
- `in_ready` is registered and equals the next-cycle !SKID valid. It is 0 only in FULL.
- `issue_count` increments on each transfer and wraps from all-ones to 0.
- Order is strictly FIFO. An entry is never duplicated or skipped.

## Timing
- Reset values: `out_valid`=0, `in_ready`=1, `a`=`b`=0, `op`=00, `illegal`=0, `issue_count`=0. SKID is empty.
- Latency is 1 cycle: an accept at edge N makes `out_valid` high after edge N.
- Throughput is 1 op/cycle while `out_ready`=1.
- ONE, accept and transfer in the same cycle: the new entry goes to OUT and the state stays ONE.
- ONE, accept with `out_ready`=0: the state becomes FULL and `in_ready` drops after the edge.
- FULL, transfer: SKID moves to OUT, the state becomes ONE, and `in_ready` rises after the edge. No accept is possible in that cycle.
- While `out_valid`=1 and `out_ready`=0, `a`/`b`/`op`/`illegal` hold stable.
- `in_*` data is ignored when `in_valid`=0 or `in_ready`=0.
- `rst` mid-operation clears OUT, SKID and the counter immediately, without waiting for a clock. Buffered entries are discarded.

## Test plan
- OR issue: rs1=32'hffff0ff0, rs2=32'h00ff0f0f, funct3=110, use_imm=0, out_ready=1 → next cycle `a`=32'hffff0ff0, `b`=32'h00ff0f0f, `op`=01, `illegal`=0, `issue_count`=1.
- Immediate select: rs1=32'h00000f00, imm=32'hffff0f00, rs2=32'h12345678, use_imm=1, funct3=111 → `b`=32'hffff0f00, `op`=10.
- Back-pressure: with out_ready=0, send 3 ops (XOR, OR, AND) back-to-back → `in_ready`=0 after the 2nd accept and the 3rd is held upstream. Then raise out_ready → outputs appear in order XOR, OR, AND with `op` 11, 01, 10 and no loss.
- Streaming: 100 random ops with out_ready=1 and in_valid=1 every cycle → 100 transfers in 101 cycles, matching a reference model, and `issue_count`=100.
- Illegal funct3: funct3=000 → `op`=00, `illegal`=1, transferred normally, and `issue_count` increments.
- Reset mid-operation: FULL state, assert `rst` → immediately `out_valid`=0, `in_ready`=1, `issue_count`=0. After release, a new op issues correctly. Also force the counter to all-ones and do one transfer → it wraps to 0.

Source files
------------

// File: rtl/alu_operand_issue.sv
// rtl/alu_operand_issue.sv - operand issue stage feeding the 32-bit OR/AND/XOR logic units
//
// Accepts rs1/rs2/imm/funct3 from decode over a valid/ready handshake. It selects
// operand b, decodes funct3 into a logic-op select, and presents registered a/b/op
// to the logic units. An output register (OUT) plus a skid register (SKID) keep the
// stage at one op per cycle under back-pressure. in_ready is a flop, so there is no
// combinational path from out_ready back to in_ready.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   in_valid/in_ready upstream handshake (in_ready registered)
//   in_rs1, in_rs2    register operands
//   in_imm            sign-extended immediate
//   in_use_imm        1: b = in_imm, 0: b = in_rs2
//   in_funct3         RISC-V funct3
//   out_valid/out_ready  downstream handshake
//   a, b, op, illegal registered outputs (op: 00 none, 01 OR, 10 AND, 11 XOR)
//   issue_count       completed output handshakes, wraps

module alu_operand_issue #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_rs1,
    input  logic [WIDTH-1:0] in_rs2,
    input  logic [WIDTH-1:0] in_imm,
    input  logic             in_use_imm,
    input  logic [2:0]       in_funct3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [1:0]       op,
    output logic             illegal,
    output logic [CNT_W-1:0] issue_count
);

    // Output register (OUT)
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_a;
    logic [WIDTH-1:0] r_out_b;
    logic [1:0]       r_out_op;
    logic             r_out_ill;

    // Skid register (SKID)
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_a;
    logic [WIDTH-1:0] r_skid_b;
    logic [1:0]       r_skid_op;
    logic             r_skid_ill;

    logic             r_in_ready;
    logic [CNT_W-1:0] r_count;

    logic             w_accept;
    logic             w_xfer;
    logic             w_out_free;
    logic [WIDTH-1:0] w_b;
    logic [1:0]       w_op;
    logic             w_ill;
    logic             w_skid_valid_next;

    assign w_accept   = in_valid && r_in_ready;
    assign w_xfer     = r_out_valid && out_ready;
    // OUT can take a new entry this edge if it is empty or its entry is leaving.
    assign w_out_free = !r_out_valid || w_xfer;
    assign w_b        = in_use_imm ? in_imm : in_rs2;

    always_comb begin
        w_op  = 2'b00;
        w_ill = 1'b0;
        case (in_funct3)
            3'b110:  w_op = 2'b01;
            3'b111:  w_op = 2'b10;
            3'b100:  w_op = 2'b11;
            default: w_ill = 1'b1;
        endcase
    end

    // SKID fills only when OUT is held; it drains whenever OUT frees up. An accept
    // never coincides with a valid SKID because in_ready is low in that state.
    always_comb begin
        w_skid_valid_next = r_skid_valid;
        if (w_out_free) begin
            w_skid_valid_next = 1'b0;
        end else if (w_accept) begin
            w_skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_a      <= '0;
            r_out_b      <= '0;
            r_out_op     <= 2'b00;
            r_out_ill    <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_a     <= '0;
            r_skid_b     <= '0;
            r_skid_op    <= 2'b00;
            r_skid_ill   <= 1'b0;
            r_in_ready   <= 1'b1;
            r_count      <= '0;
        end else begin
            r_skid_valid <= w_skid_valid_next;
            r_in_ready   <= !w_skid_valid_next;

            if (w_xfer) begin
                r_count <= r_count + 1'b1;
            end

            if (w_out_free) begin
                if (r_skid_valid) begin
                    r_out_valid <= 1'b1;
                    r_out_a     <= r_skid_a;
                    r_out_b     <= r_skid_b;
                    r_out_op    <= r_skid_op;
                    r_out_ill   <= r_skid_ill;
                end else if (w_accept) begin
                    r_out_valid <= 1'b1;
                    r_out_a     <= in_rs1;
                    r_out_b     <= w_b;
                    r_out_op    <= w_op;
                    r_out_ill   <= w_ill;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_accept) begin
                r_skid_a   <= in_rs1;
                r_skid_b   <= w_b;
                r_skid_op  <= w_op;
                r_skid_ill <= w_ill;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign a           = r_out_a;
    assign b           = r_out_b;
    assign op          = r_out_op;
    assign illegal     = r_out_ill;
    assign issue_count = r_count;

endmodule

// File: tb/tb_alu_operand_issue.sv
// tb/tb_alu_operand_issue.sv - self-checking bench for alu_operand_issue
module tb_alu_operand_issue;

    localparam int WIDTH = 32;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_rs1;
    logic [WIDTH-1:0] in_rs2;
    logic [WIDTH-1:0] in_imm;
    logic             in_use_imm;
    logic [2:0]       in_funct3;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             illegal;
    logic [CNT_W-1:0] issue_count;

    alu_operand_issue #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_funct3(in_funct3),
        .out_valid(out_valid), .out_ready(out_ready),
        .a(a), .b(b), .op(op), .illegal(illegal),
        .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] ea;
        logic [WIDTH-1:0] eb;
        logic [1:0]       eop;
        logic             eill;
    } entry_t;

    entry_t     q[$];
    int         m_cnt;
    int         n_total;
    int         n_pass;
    int         n_xfer;
    logic [1:0] xfer_ops[$];

    function automatic logic [1:0] ref_op(input logic [2:0] f);
        if (f == 3'd6) return 2'd1;
        if (f == 3'd7) return 2'd2;
        if (f == 3'd4) return 2'd3;
        return 2'd0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic use_imm, input logic [2:0] f3,
                         input logic ordy);
        in_valid   = v;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_imm     = imm;
        in_use_imm = use_imm;
        in_funct3  = f3;
        out_ready  = ordy;
    endtask

    // One clock: compare DUT against the model mid-cycle, then advance the model
    // with the handshakes that happen at the coming edge.
    task automatic cycle();
        entry_t e;
        logic   acc;
        logic   xf;
        @(negedge clk);
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        chk("issue_count", 64'(issue_count), 64'(m_cnt));
        if (q.size() > 0) begin
            chk("a", 64'(a), 64'(q[0].ea));
            chk("b", 64'(b), 64'(q[0].eb));
            chk("op", 64'(op), 64'(q[0].eop));
            chk("illegal", 64'(illegal), 64'(q[0].eill));
        end
        acc = in_valid && (q.size() < 2);
        xf  = (q.size() > 0) && out_ready;
        if (xf) begin
            xfer_ops.push_back(q[0].eop);
            void'(q.pop_front());
            m_cnt = (m_cnt + 1) % (1 << CNT_W);
            n_xfer++;
        end
        if (acc) begin
            e.ea   = in_rs1;
            e.eb   = in_use_imm ? in_imm : in_rs2;
            e.eop  = ref_op(in_funct3);
            e.eill = (ref_op(in_funct3) == 2'd0);
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        drive(1'b0, 0, 0, 0, 1'b0, 3'd0, 1'b1);
        while (q.size() > 0 && guard < 10) begin
            cycle();
            guard++;
        end
        chk("drain_done", 64'(q.size()), 64'd0);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        n_xfer  = 0;
        m_cnt   = 0;
        rst     = 1'b1;
        drive(1'b0, 0, 0, 0, 1'b0, 3'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset values
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_a", 64'(a), 64'd0);
        chk("rst_b", 64'(b), 64'd0);
        chk("rst_op", 64'(op), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);
        chk("rst_count", 64'(issue_count), 64'd0);
        cycle();

        // OR issue
        drive(1'b1, 32'hffff0ff0, 32'h00ff0f0f, 32'h0, 1'b0, 3'b110, 1'b1);
        cycle();
        drive(1'b0, 0, 0, 0, 1'b0, 3'd0, 1'b1);
        chk("or_a", 64'(a), 64'hffff0ff0);
        chk("or_b", 64'(b), 64'h00ff0f0f);
        chk("or_op", 64'(op), 64'd1);
        chk("or_ill", 64'(illegal), 64'd0);
        cycle();
        chk("or_count", 64'(issue_count), 64'd1);

        // Immediate select
        drive(1'b1, 32'h00000f00, 32'h12345678, 32'hffff0f00, 1'b1, 3'b111, 1'b1);
        cycle();
        drive(1'b0, 0, 0, 0, 1'b0, 3'd0, 1'b1);
        chk("imm_b", 64'(b), 64'hffff0f00);
        chk("imm_op", 64'(op), 64'd2);
        cycle();

        // Illegal funct3
        drive(1'b1, 32'h1111, 32'h2222, 32'h0, 1'b0, 3'b000, 1'b1);
        cycle();
        drive(1'b0, 0, 0, 0, 1'b0, 3'd0, 1'b1);
        chk("ill_op", 64'(op), 64'd0);
        chk("ill_flag", 64'(illegal), 64'd1);
        cycle();
        chk("ill_count", 64'(issue_count), 64'd3);

        // Back-pressure: XOR, OR, AND with out_ready low
        xfer_ops.delete();
        drive(1'b1, 32'hA, 32'h1, 32'h0, 1'b0, 3'b100, 1'b0);
        cycle();
        drive(1'b1, 32'hB, 32'h2, 32'h0, 1'b0, 3'b110, 1'b0);
        cycle();
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        drive(1'b1, 32'hC, 32'h3, 32'h0, 1'b0, 3'b111, 1'b0);
        cycle();
        chk("bp_held", 64'(in_ready), 64'd0);
        chk("bp_op_stable", 64'(op), 64'd3);
        drive(1'b1, 32'hC, 32'h3, 32'h0, 1'b0, 3'b111, 1'b1);
        cycle();
        chk("bp_in_ready_rise", 64'(in_ready), 64'd1);
        cycle();
        drain();
        chk("bp_nxfer", 64'(xfer_ops.size()), 64'd3);
        if (xfer_ops.size() == 3) begin
            chk("bp_order0", 64'(xfer_ops[0]), 64'd3);
            chk("bp_order1", 64'(xfer_ops[1]), 64'd1);
            chk("bp_order2", 64'(xfer_ops[2]), 64'd2);
        end

        // Reset while FULL, asserted between edges
        drive(1'b1, 32'h55, 32'h66, 32'h0, 1'b0, 3'b100, 1'b0);
        cycle();
        cycle();
        chk("full_before_rst", 64'(in_ready), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_count", 64'(issue_count), 64'd0);
        q.delete();
        m_cnt = 0;
        drive(1'b0, 0, 0, 0, 1'b0, 3'd0, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 32'hdeadbeef, 32'h0, 32'h0f0f0f0f, 1'b1, 3'b100, 1'b1);
        cycle();
        drive(1'b0, 0, 0, 0, 1'b0, 3'd0, 1'b1);
        chk("post_rst_a", 64'(a), 64'hdeadbeef);
        chk("post_rst_b", 64'(b), 64'h0f0f0f0f);
        cycle();
        chk("post_rst_count", 64'(issue_count), 64'd1);

        // Streaming: 100 random ops back-to-back
        m_cnt = 0;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        q.delete();
        n_xfer = 0;
        for (int i = 0; i < 101; i++) begin
            if (i < 100)
                drive(1'b1, $urandom, $urandom, $urandom, 1'($urandom), 3'($urandom), 1'b1);
            else
                drive(1'b0, 0, 0, 0, 1'b0, 3'd0, 1'b1);
            cycle();
        end
        chk("stream_xfers", 64'(n_xfer), 64'd100);
        chk("stream_count", 64'(issue_count), 64'd100);

        // Random valid / back-pressure mix
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom), $urandom, $urandom, $urandom, 1'($urandom),
                  3'($urandom), 1'($urandom));
            cycle();
        end
        drain();

        // Counter wrap
        begin
            int guard;
            guard = 0;
            while (m_cnt != 255 && guard < 600) begin
                if (m_cnt == 254 && q.size() > 0)
                    drive(1'b0, 0, 0, 0, 1'b0, 3'd0, 1'b1);
                else
                    drive(1'b1, $urandom, $urandom, $urandom, 1'b0, 3'b110, 1'b1);
                cycle();
                guard++;
            end
        end
        chk("wrap_pre", 64'(issue_count), 64'd255);
        drive(1'b1, 32'h7, 32'h8, 32'h0, 1'b0, 3'b111, 1'b1);
        cycle();
        drive(1'b0, 0, 0, 0, 1'b0, 3'd0, 1'b1);
        cycle();
        chk("wrap_zero", 64'(issue_count), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
